// File: rtl/led_pattern_monitor.sv
// led_pattern_monitor
//   Receive-side checker for the 8-bit LED flower-pattern bus. It hunts for
//   the sync word 0x42, verifies LOCK_CNT consecutive matching samples, then
//   flywheels through the 46-step frame. It reports lock status, the current
//   flower and step, and keeps a count of sequence errors.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active-low
//   en         - sample strobe; d is evaluated only when en=1
//   d[7:0]     - LED bus sample
//   clr_err    - synchronous clear of err_count (wins over an increment)
//   locked     - 1 while in LOCKED
//   pattern_id - flower (0..3) of the last accepted sample, 0 when unlocked
//   step       - frame index (0..45) of the last accepted sample, 0 when unlocked
//   frame_done - one-cycle pulse on a matching index-45 sample while LOCKED
//   err        - one-cycle pulse on each LOCKED mismatch
//   err_count  - saturating count of LOCKED mismatches
module led_pattern_monitor #(
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned UNLOCK_MISS = 3,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       d,
    input  logic             clr_err,
    output logic             locked,
    output logic [1:0]       pattern_id,
    output logic [5:0]       step,
    output logic             frame_done,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

    localparam logic [7:0] SYNC_WORD = 8'h42;
    localparam logic [3:0] LC        = 4'(LOCK_CNT);
    localparam logic [3:0] UM        = 4'(UNLOCK_MISS);

    function automatic logic [7:0] f_frame(input logic [5:0] i);
        logic [7:0] v;
        case (i)
            6'd0:  v = 8'h00; 6'd1:  v = 8'h81; 6'd2:  v = 8'h42; 6'd3:  v = 8'h24;
            6'd4:  v = 8'h18; 6'd5:  v = 8'h00; 6'd6:  v = 8'h18; 6'd7:  v = 8'h3C;
            6'd8:  v = 8'h7E; 6'd9:  v = 8'hFF; 6'd10: v = 8'hE7; 6'd11: v = 8'hC3;
            6'd12: v = 8'h81; 6'd13: v = 8'h00; 6'd14: v = 8'h80; 6'd15: v = 8'hC0;
            6'd16: v = 8'hE0; 6'd17: v = 8'hF0; 6'd18: v = 8'hF8; 6'd19: v = 8'hFC;
            6'd20: v = 8'hFE; 6'd21: v = 8'hFF; 6'd22: v = 8'hFE; 6'd23: v = 8'hFC;
            6'd24: v = 8'hF8; 6'd25: v = 8'hF0; 6'd26: v = 8'hE0; 6'd27: v = 8'hC0;
            6'd28: v = 8'h80; 6'd29: v = 8'h00; 6'd30: v = 8'h01; 6'd31: v = 8'h03;
            6'd32: v = 8'h07; 6'd33: v = 8'h0F; 6'd34: v = 8'h1F; 6'd35: v = 8'h3F;
            6'd36: v = 8'h7F; 6'd37: v = 8'hFF; 6'd38: v = 8'h7F; 6'd39: v = 8'h3F;
            6'd40: v = 8'h1F; 6'd41: v = 8'h0F; 6'd42: v = 8'h07; 6'd43: v = 8'h03;
            6'd44: v = 8'h01; default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] f_pid(input logic [5:0] i);
        if (i <= 6'd5)       return 2'd0;
        else if (i <= 6'd13) return 2'd1;
        else if (i <= 6'd29) return 2'd2;
        else                 return 2'd3;
    endfunction

    state_t      r_state, w_state_nx;
    logic [5:0]  r_idx, w_idx_nx, w_idx_inc;
    logic [3:0]  r_match, w_match_nx;
    logic [3:0]  r_miss, w_miss_nx;
    logic [5:0]  r_step, w_step_nx;
    logic [1:0]  r_pid, w_pid_nx;
    logic        r_fd, w_fd_nx;
    logic        r_err, w_err_nx;
    logic        w_inc;
    logic        w_hit;
    logic [ERR_W-1:0] r_cnt;

    assign w_idx_inc = (r_idx == 6'd45) ? 6'd0 : r_idx + 6'd1;
    assign w_hit     = (d == f_frame(r_idx));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_HUNT;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_match_nx = r_match;
        w_miss_nx  = r_miss;
        w_step_nx  = r_step;
        w_pid_nx   = r_pid;
        w_fd_nx    = 1'b0;
        w_err_nx   = 1'b0;
        w_inc      = 1'b0;
        if (en) begin
            case (r_state)
                S_HUNT, S_VERIFY: begin
                    if (r_state == S_VERIFY && w_hit) begin
                        w_idx_nx   = w_idx_inc;
                        w_match_nx = r_match + 4'd1;
                        if (r_match + 4'd1 >= LC) begin
                            w_state_nx = S_LOCKED;
                            w_miss_nx  = '0;
                            w_step_nx  = r_idx;
                            w_pid_nx   = f_pid(r_idx);
                        end
                    end else if (d == SYNC_WORD) begin
                        // A VERIFY mismatch falls back to HUNT and the same
                        // sample is taken as a fresh sync candidate.
                        w_idx_nx   = 6'd3;
                        w_match_nx = 4'd1;
                        w_state_nx = S_VERIFY;
                        if (LC <= 4'd1) begin
                            w_state_nx = S_LOCKED;
                            w_miss_nx  = '0;
                            w_step_nx  = 6'd2;
                            w_pid_nx   = 2'd0;
                        end
                    end else begin
                        w_state_nx = S_HUNT;
                        w_idx_nx   = '0;
                        w_match_nx = '0;
                    end
                end
                S_LOCKED: begin
                    // Flywheel: the pointer advances on every sample.
                    w_idx_nx  = w_idx_inc;
                    w_step_nx = r_idx;
                    w_pid_nx  = f_pid(r_idx);
                    if (w_hit) begin
                        w_miss_nx = '0;
                        w_fd_nx   = (r_idx == 6'd45);
                    end else begin
                        w_err_nx  = 1'b1;
                        w_inc     = 1'b1;
                        w_miss_nx = r_miss + 4'd1;
                        if (r_miss + 4'd1 >= UM) begin
                            w_state_nx = S_HUNT;
                            w_idx_nx   = '0;
                            w_match_nx = '0;
                            w_miss_nx  = '0;
                            w_step_nx  = '0;
                            w_pid_nx   = '0;
                        end
                    end
                end
                default: begin
                    w_state_nx = S_HUNT;
                    w_idx_nx   = '0;
                    w_match_nx = '0;
                    w_miss_nx  = '0;
                    w_step_nx  = '0;
                    w_pid_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_match <= '0;
            r_miss  <= '0;
            r_step  <= '0;
            r_pid   <= '0;
            r_fd    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_idx   <= w_idx_nx;
            r_match <= w_match_nx;
            r_miss  <= w_miss_nx;
            r_step  <= w_step_nx;
            r_pid   <= w_pid_nx;
            r_fd    <= w_fd_nx;
            r_err   <= w_err_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      r_cnt <= '0;
        else if (clr_err)              r_cnt <= '0;
        else if (w_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    assign locked     = (r_state == S_LOCKED);
    assign pattern_id = r_pid;
    assign step       = r_step;
    assign frame_done = r_fd;
    assign err        = r_err;
    assign err_count  = r_cnt;

endmodule

// File: tb/tb_led_pattern_monitor.sv
// tb_led_pattern_monitor
//   Directed bench for led_pattern_monitor: a vector table for the basic lock
//   and single-error behaviour, then hand-written sequences for strobed input,
//   unlock/relock, VERIFY re-sync, clr_err priority, saturation and reset.
module tb_led_pattern_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] d = 8'h00;
    logic       clr_err = 1'b0;
    logic       locked;
    logic [1:0] pattern_id;
    logic [5:0] step;
    logic       frame_done;
    logic       err;
    logic [3:0] err_count;

    int total = 0;
    int bad   = 0;

    led_pattern_monitor #(.LOCK_CNT(4), .UNLOCK_MISS(3), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .d(d), .clr_err(clr_err),
        .locked(locked), .pattern_id(pattern_id), .step(step),
        .frame_done(frame_done), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    logic [7:0] frame [46] = '{
        8'h00, 8'h81, 8'h42, 8'h24, 8'h18, 8'h00,
        8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hE7, 8'hC3, 8'h81, 8'h00,
        8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
        8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00,
        8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
        8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

    function automatic logic [1:0] pid_of(input int i);
        if (i < 6) return 2'd0;
        if (i < 14) return 2'd1;
        if (i < 30) return 2'd2;
        return 2'd3;
    endfunction

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic       clr;
        logic       l;
        logic [1:0] p;
        logic [5:0] s;
        logic       fd;
        logic       e;
        logic [3:0] c;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input logic [1:0] p,
                           input logic [5:0] s, input logic fd, input logic e,
                           input logic [3:0] c);
        chk({tag, ".locked"}, 32'(locked), 32'(l));
        chk({tag, ".pattern_id"}, 32'(pattern_id), 32'(p));
        chk({tag, ".step"}, 32'(step), 32'(s));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
        chk({tag, ".err"}, 32'(err), 32'(e));
        chk({tag, ".err_count"}, 32'(err_count), 32'(c));
    endtask

    task automatic cyc(input logic e, input logic [7:0] v, input logic c);
        en = e; d = v; clr_err = c;
        @(posedge clk);
        #1;
        en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // 42,24,18,00 from HUNT: locked with step 5 afterwards, pointer at 6.
    task automatic lock_seq(input string tag, input logic [3:0] c);
        cyc(1'b1, 8'h42, 1'b0);
        cyc(1'b1, 8'h24, 1'b0);
        cyc(1'b1, 8'h18, 1'b0);
        chk({tag, ".pre_lock"}, 32'(locked), 32'd0);
        cyc(1'b1, 8'h00, 1'b0);
        chk_all({tag, ".lock"}, 1'b1, 2'd0, 6'd5, 1'b0, 1'b0, c);
    endtask

    initial begin
        int idx;
        int n;
        int fd_seen;

        tv[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b0, 4'd0};
        tv[1]  = '{1'b1, 8'h81, 1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b0, 4'd0};
        tv[2]  = '{1'b1, 8'h42, 1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b0, 4'd0};
        tv[3]  = '{1'b1, 8'h24, 1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b0, 4'd0};
        tv[4]  = '{1'b1, 8'h18, 1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b0, 4'd0};
        tv[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 2'd0, 6'd5,  1'b0, 1'b0, 4'd0};
        tv[6]  = '{1'b1, 8'h18, 1'b0, 1'b1, 2'd1, 6'd6,  1'b0, 1'b0, 4'd0};
        tv[7]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 2'd1, 6'd7,  1'b0, 1'b0, 4'd0};
        tv[8]  = '{1'b1, 8'h7F, 1'b0, 1'b1, 2'd1, 6'd8,  1'b0, 1'b1, 4'd1};
        tv[9]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 2'd1, 6'd9,  1'b0, 1'b0, 4'd1};
        tv[10] = '{1'b1, 8'hE7, 1'b0, 1'b1, 2'd1, 6'd10, 1'b0, 1'b0, 4'd1};
        tv[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 6'd10, 1'b0, 1'b0, 4'd1};
        tv[12] = '{1'b1, 8'hC3, 1'b0, 1'b1, 2'd1, 6'd11, 1'b0, 1'b0, 4'd1};

        // Reset state
        #2;
        chk_all("reset", 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 4'd0);
        do_reset();

        // Table: lock from index 0, single corrupted sample, en=0 hold
        for (int i = 0; i < 13; i++) begin
            cyc(tv[i].en, tv[i].d, tv[i].clr);
            chk_all($sformatf("tv%0d", i), tv[i].l, tv[i].p, tv[i].s,
                    tv[i].fd, tv[i].e, tv[i].c);
        end
        // Rest of the frame, frame_done only at index 45
        for (int i = 12; i < 46; i++) begin
            cyc(1'b1, frame[i], 1'b0);
            chk_all($sformatf("run%0d", i), 1'b1, pid_of(i), 6'(i),
                    (i == 45), 1'b0, 4'd1);
        end
        cyc(1'b1, frame[0], 1'b0);
        chk_all("wrap0", 1'b1, 2'd0, 6'd0, 1'b0, 1'b0, 4'd1);
        fd_seen = 0;
        for (int i = 1; i < 47; i++) begin
            cyc(1'b1, frame[i % 46], 1'b0);
            if (frame_done) fd_seen++;
        end
        chk("fd_per_frame", 32'(fd_seen), 32'd1);

        // Strobe every 3rd cycle; outputs hold between strobes
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, frame[i], 1'b0);
            chk_all($sformatf("strb%0d", i), (i >= 5), (i >= 5) ? pid_of(i) : 2'd0,
                    (i >= 5) ? 6'(i) : 6'd0, 1'b0, 1'b0, 4'd0);
            for (int k = 0; k < 2; k++) begin
                cyc(1'b0, 8'h5A, 1'b0);
                chk_all($sformatf("idle%0d_%0d", i, k), (i >= 5),
                        (i >= 5) ? pid_of(i) : 2'd0,
                        (i >= 5) ? 6'(i) : 6'd0, 1'b0, 1'b0, 4'd0);
            end
        end

        // Three consecutive misses unlock, then relock
        cyc(1'b1, 8'h00, 1'b0);
        chk_all("miss1", 1'b1, 2'd2, 6'd14, 1'b0, 1'b1, 4'd1);
        cyc(1'b1, 8'h00, 1'b0);
        chk_all("miss2", 1'b1, 2'd2, 6'd15, 1'b0, 1'b1, 4'd2);
        cyc(1'b1, 8'h00, 1'b0);
        chk_all("miss3", 1'b0, 2'd0, 6'd0, 1'b0, 1'b1, 4'd3);
        cyc(1'b1, 8'h00, 1'b0);
        chk_all("hunt", 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 4'd3);
        lock_seq("relock", 4'd3);

        // VERIFY re-sync on a stray 42
        do_reset();
        cyc(1'b1, 8'h42, 1'b0);
        cyc(1'b1, 8'h24, 1'b0);
        cyc(1'b1, 8'h42, 1'b0);
        chk("resync.locked", 32'(locked), 32'd0);
        lock_seq("resync", 4'd0);

        // clr_err wins over a simultaneous LOCKED mismatch at count 5
        do_reset();
        lock_seq("clr", 4'd0);
        idx = 6;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, frame[idx] ^ 8'h01, 1'b0);
            chk_all($sformatf("clr_miss%0d", k), 1'b1, pid_of(idx), 6'(idx),
                    1'b0, 1'b1, 4'(k + 1));
            idx++;
            cyc(1'b1, frame[idx], 1'b0);
            idx++;
        end
        cyc(1'b1, frame[idx] ^ 8'h01, 1'b1);
        chk_all("clr_win", 1'b1, pid_of(idx), 6'(idx), 1'b0, 1'b1, 4'd0);

        // Saturation: 18 mismatches on a 4-bit counter
        do_reset();
        n = 0;
        for (int r = 0; r < 6; r++) begin
            lock_seq($sformatf("sat_lock%0d", r), 4'((n > 15) ? 15 : n));
            for (int k = 0; k < 3; k++) begin
                cyc(1'b1, 8'h00, 1'b0);
                n++;
                chk($sformatf("sat_cnt%0d", n), 32'(err_count),
                    32'((n > 15) ? 15 : n));
            end
            chk($sformatf("sat_unlock%0d", r), 32'(locked), 32'd0);
        end
        chk("sat_final", 32'(err_count), 32'd15);

        // Asynchronous reset mid-frame
        lock_seq("mid", 4'd15);
        cyc(1'b1, frame[6], 1'b0);
        cyc(1'b1, frame[7], 1'b0);
        chk_all("pre_rst", 1'b1, 2'd1, 6'd7, 1'b0, 1'b0, 4'd15);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 4'd0);
        #2;
        rst = 1'b1;
        cyc(1'b1, frame[8], 1'b0);
        chk_all("post_rst", 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
